// File: rtl/grf_wb_arbiter_pkg.sv
// Shared types for the GRF write-back arbiter: FSM states and the buffered
// late-result record. Pure declarations, no logic.
// Imported by the arbiter top and its FIFO sub-module.
package grf_wb_arbiter_pkg;

   localparam int REG_W  = 5;
   localparam int DATA_W = 32;

   // NORMAL: pipeline has priority; FORCE: pipeline is asked to bubble so the FIFO drains
   typedef enum logic {
      NORMAL = 1'b0,
      FORCE  = 1'b1
   } wb_state_e;

   // One buffered late write-back; valid drops when a younger pipeline write kills it
   typedef struct packed {
      logic              valid;
      logic [REG_W-1:0]  a3;
      logic [DATA_W-1:0] wd;
      logic [DATA_W-1:0] pc;
   } wb_entry_t;

   // True when a register number names a real destination ($0 writes are discarded)
   function automatic logic is_real_reg(input logic [REG_W-1:0] a);
      return a != '0;
   endfunction

endpackage

// File: rtl/grf_wb_arbiter_wb_fifo.sv
// Late write-back FIFO with per-entry kill, head skip of killed entries and
// register-match query ports. Enqueue visible at the head the cycle after
// acceptance; the caller must not enqueue when full (no same-cycle bypass).
module wb_fifo
   import grf_wb_arbiter_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int PW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enq_i,
   input  logic [REG_W-1:0]  enq_a3_i,
   input  logic [DATA_W-1:0] enq_wd_i,
   input  logic [DATA_W-1:0] enq_pc_i,
   input  logic              deq_i,
   input  logic              inv_i,
   input  logic [REG_W-1:0]  inv_a3_i,
   output wb_entry_t         head_o,
   output logic [CW-1:0]     count_o,
   output logic [CW-1:0]     count_nxt_o,
   input  logic [REG_W-1:0]  q_a1_i,
   input  logic [REG_W-1:0]  q_a2_i,
   output logic              q_busy1_o,
   output logic              q_busy2_o,
   output logic [DATA_W-1:0] q_fwd1_o,
   output logic [DATA_W-1:0] q_fwd2_o
);

   wb_entry_t      mem_q [DEPTH];
   wb_entry_t      mem_d [DEPTH];
   logic [PW-1:0]  wr_q, wr_d;
   logic [PW-1:0]  rd_q, rd_d;
   logic [CW-1:0]  cnt_q, cnt_d;

   // Next state: kill, pop, push, then advance past killed entries so the head is always live
   always_comb begin
      mem_d = mem_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      cnt_d = cnt_q;

      if (inv_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (mem_q[i].a3 == inv_a3_i) begin
               mem_d[i].valid = 1'b0;
            end
         end
      end

      if (deq_i && (cnt_q != '0)) begin
         mem_d[rd_q].valid = 1'b0;
         rd_d  = rd_q + PW'(1);
         cnt_d = cnt_d - CW'(1);
      end

      // Full check uses the pre-edge count: a slot freed this cycle is not reusable yet
      if (enq_i && (cnt_q < CW'(DEPTH))) begin
         mem_d[wr_q].valid = 1'b1;
         mem_d[wr_q].a3    = enq_a3_i;
         mem_d[wr_q].wd    = enq_wd_i;
         mem_d[wr_q].pc    = enq_pc_i;
         wr_d  = wr_q + PW'(1);
         cnt_d = cnt_d + CW'(1);
      end

      // Killed entries reaching the head are retired here so they never cost a port cycle
      for (int k = 0; k < DEPTH; k++) begin
         if ((cnt_d != '0) && !mem_d[rd_d].valid) begin
            rd_d  = rd_d + PW'(1);
            cnt_d = cnt_d - CW'(1);
         end
      end
   end

   // Storage and pointer registers; reset discards every buffered entry
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
         end
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         cnt_q <= cnt_d;
      end
   end

   assign head_o      = mem_q[rd_q];
   assign count_o     = cnt_q;
   assign count_nxt_o = cnt_d;

   // Query scan oldest to youngest so the youngest live match supplies the forward data
   always_comb begin : query_scan
      wb_entry_t     e;
      logic [PW-1:0] idx;
      e         = '0;
      idx       = '0;
      q_busy1_o = 1'b0;
      q_busy2_o = 1'b0;
      q_fwd1_o  = '0;
      q_fwd2_o  = '0;
      for (int k = 0; k < DEPTH; k++) begin
         idx = rd_q + PW'(k);
         e   = mem_q[idx];
         if (e.valid && is_real_reg(q_a1_i) && (e.a3 == q_a1_i)) begin
            q_busy1_o = 1'b1;
            q_fwd1_o  = e.wd;
         end
         if (e.valid && is_real_reg(q_a2_i) && (e.a3 == q_a2_i)) begin
            q_busy2_o = 1'b1;
            q_fwd2_o  = e.wd;
         end
      end
   end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Arbitrates the single GRF write port between the W-stage and buffered MDU results.
// Pipeline writes go out with zero latency; buffered results one or more cycles after acceptance.
// mdu_ready drops when the FIFO is full; stall_req asks the pipeline to bubble so the FIFO drains.
module grf_wb_arbiter
   import grf_wb_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = 2,
   parameter int AGE_MAX    = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              pipe_we,
   input  logic [REG_W-1:0]  pipe_a3,
   input  logic [DATA_W-1:0] pipe_wd,
   input  logic [DATA_W-1:0] pipe_pc,
   input  logic              mdu_valid,
   input  logic [REG_W-1:0]  mdu_a3,
   input  logic [DATA_W-1:0] mdu_wd,
   input  logic [DATA_W-1:0] mdu_pc,
   output logic              mdu_ready,
   input  logic [REG_W-1:0]  q_a1,
   input  logic [REG_W-1:0]  q_a2,
   output logic              q_busy1,
   output logic              q_busy2,
   output logic [DATA_W-1:0] q_fwd1,
   output logic [DATA_W-1:0] q_fwd2,
   output logic              grf_we,
   output logic [REG_W-1:0]  grf_a3,
   output logic [DATA_W-1:0] grf_wd,
   output logic [DATA_W-1:0] grf_pc,
   output logic              stall_req,
   output logic              proto_err
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int AW = $clog2(AGE_MAX + 1);

   wb_entry_t      head;
   logic [CW-1:0]  count;
   logic [CW-1:0]  count_nxt;
   logic           head_vld;
   logic           pipe_sel;
   logic           deq;
   logic           enq;
   logic           inv;

   wb_state_e      state_q, state_d;
   logic [AW-1:0]  age_q, age_d;
   logic           proto_q, proto_d;

   assign head_vld  = (count != '0) && head.valid;
   assign pipe_sel  = pipe_we && is_real_reg(pipe_a3);
   assign mdu_ready = count < CW'(FIFO_DEPTH);

   // Pop only when the port is free; a live pipeline write always takes the port
   assign deq = !reset && !pipe_sel && head_vld;
   assign inv = !reset && pipe_sel;

   // A result already overwritten by this cycle's pipeline write is dead on arrival, as is $0
   assign enq = !reset && mdu_valid && mdu_ready && is_real_reg(mdu_a3)
              && !(pipe_sel && (pipe_a3 == mdu_a3));

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk         (clk),
      .reset       (reset),
      .enq_i       (enq),
      .enq_a3_i    (mdu_a3),
      .enq_wd_i    (mdu_wd),
      .enq_pc_i    (mdu_pc),
      .deq_i       (deq),
      .inv_i       (inv),
      .inv_a3_i    (pipe_a3),
      .head_o      (head),
      .count_o     (count),
      .count_nxt_o (count_nxt),
      .q_a1_i      (q_a1),
      .q_a2_i      (q_a2),
      .q_busy1_o   (q_busy1),
      .q_busy2_o   (q_busy2),
      .q_fwd1_o    (q_fwd1),
      .q_fwd2_o    (q_fwd2)
   );

   // Write-port mux: pipeline first, then FIFO head, otherwise an all-zero idle port
   always_comb begin
      grf_we = 1'b0;
      grf_a3 = '0;
      grf_wd = '0;
      grf_pc = '0;
      if (!reset) begin
         if (pipe_sel) begin
            grf_we = 1'b1;
            grf_a3 = pipe_a3;
            grf_wd = pipe_wd;
            grf_pc = pipe_pc;
         end else if (head_vld) begin
            grf_we = 1'b1;
            grf_a3 = head.a3;
            grf_wd = head.wd;
            grf_pc = head.pc;
         end
      end
   end

   // Head age: counts cycles the live head is passed over, saturating
   always_comb begin
      age_d = age_q;
      if (!head_vld || deq) begin
         age_d = '0;
      end else if (age_q < AW'(AGE_MAX)) begin
         age_d = age_q + AW'(1);
      end
   end

   // Drain FSM: force when the head has starved long enough or the FIFO is full
   always_comb begin
      state_d = state_q;
      case (state_q)
         NORMAL: begin
            if ((count_nxt != '0) &&
                ((head_vld && !deq && (age_q >= AW'(AGE_MAX - 1))) ||
                 (count == CW'(FIFO_DEPTH)))) begin
               state_d = FORCE;
            end
         end
         FORCE: begin
            if (count_nxt == '0) begin
               state_d = NORMAL;
            end
         end
         default: state_d = NORMAL;
      endcase
   end

   // A pipeline write while a bubble is requested is a protocol violation; sticky until reset
   assign proto_d = proto_q || (pipe_we && (state_q == FORCE));

   // Control state registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= NORMAL;
         age_q   <= '0;
         proto_q <= 1'b0;
      end else begin
         state_q <= state_d;
         age_q   <= age_d;
         proto_q <= proto_d;
      end
   end

   assign stall_req = (state_q == FORCE);
   assign proto_err = proto_q;

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Bench for grf_wb_arbiter: vector table for the arbitration/age sequence plus
// hand-written WAW, full-FIFO, protocol and mid-drain reset sequences.
// Every GRF write is checked in order against a queue of expected writes.
module tb_grf_wb_arbiter;

   logic        clk;
   logic        reset;
   logic        pipe_we;
   logic [4:0]  pipe_a3;
   logic [31:0] pipe_wd;
   logic [31:0] pipe_pc;
   logic        mdu_valid;
   logic [4:0]  mdu_a3;
   logic [31:0] mdu_wd;
   logic [31:0] mdu_pc;
   logic        mdu_ready;
   logic [4:0]  q_a1;
   logic [4:0]  q_a2;
   logic        q_busy1;
   logic        q_busy2;
   logic [31:0] q_fwd1;
   logic [31:0] q_fwd2;
   logic        grf_we;
   logic [4:0]  grf_a3;
   logic [31:0] grf_wd;
   logic [31:0] grf_pc;
   logic        stall_req;
   logic        proto_err;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [4:0]  a3;
      logic [31:0] wd;
      logic [31:0] pc;
   } wr_t;

   wr_t exp_q [$];

   typedef struct {
      logic       pwe;
      logic [4:0] pa3;
      logic       mv;
      logic [4:0] ma3;
      logic [4:0] qa;
      logic       exp_we;
      logic [4:0] exp_a3;
      logic       exp_mdu;
      logic       exp_stall;
      logic       exp_rdy;
      logic       exp_busy;
   } vec_t;

   vec_t vecs [10];

   grf_wb_arbiter #(
      .FIFO_DEPTH (2),
      .AGE_MAX    (4)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .pipe_we   (pipe_we),
      .pipe_a3   (pipe_a3),
      .pipe_wd   (pipe_wd),
      .pipe_pc   (pipe_pc),
      .mdu_valid (mdu_valid),
      .mdu_a3    (mdu_a3),
      .mdu_wd    (mdu_wd),
      .mdu_pc    (mdu_pc),
      .mdu_ready (mdu_ready),
      .q_a1      (q_a1),
      .q_a2      (q_a2),
      .q_busy1   (q_busy1),
      .q_busy2   (q_busy2),
      .q_fwd1    (q_fwd1),
      .q_fwd2    (q_fwd2),
      .grf_we    (grf_we),
      .grf_a3    (grf_a3),
      .grf_wd    (grf_wd),
      .grf_pc    (grf_pc),
      .stall_req (stall_req),
      .proto_err (proto_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] pwd(input logic [4:0] a);
      return 32'h1000_0000 | {27'd0, a};
   endfunction
   function automatic logic [31:0] ppc(input logic [4:0] a);
      return 32'h0000_3000 + {25'd0, a, 2'b00};
   endfunction
   function automatic logic [31:0] mwd(input logic [4:0] a);
      return 32'h2000_0000 | {27'd0, a};
   endfunction
   function automatic logic [31:0] mpc(input logic [4:0] a);
      return 32'h0000_4000 + {25'd0, a, 2'b00};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      pipe_we   = 1'b0; pipe_a3 = '0; pipe_wd = '0; pipe_pc = '0;
      mdu_valid = 1'b0; mdu_a3  = '0; mdu_wd  = '0; mdu_pc  = '0;
   endtask

   task automatic set_pipe(input logic [4:0] a, input logic [31:0] wd, input logic [31:0] pc,
                           input logic expect_write);
      pipe_we = 1'b1; pipe_a3 = a; pipe_wd = wd; pipe_pc = pc;
      if (expect_write) exp_q.push_back('{a3: a, wd: wd, pc: pc});
   endtask

   task automatic set_mdu(input logic [4:0] a, input logic [31:0] wd, input logic [31:0] pc);
      mdu_valid = 1'b1; mdu_a3 = a; mdu_wd = wd; mdu_pc = pc;
   endtask

   // Write monitor: each GRF write must be the next expected one, in order
   always @(negedge clk) begin : wr_monitor
      wr_t e;
      if (grf_we === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: got a3=%0d wd=%h expected no write (t=%0t)",
                     grf_a3, grf_wd, $time);
         end else begin
            e = exp_q.pop_front();
            chk("grf_a3", {27'd0, grf_a3}, {27'd0, e.a3});
            chk("grf_wd", grf_wd, e.wd);
            chk("grf_pc", grf_pc, e.pc);
         end
      end
   end

   initial begin
      // pwe pa3 mv ma3 qa | we a3 mdu stall rdy busy
      vecs[0] = '{1'b1, 5'd3, 1'b1, 5'd7, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 5'd3, 1'b0, 5'd0, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[2] = '{1'b1, 5'd3, 1'b0, 5'd0, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[3] = '{1'b1, 5'd3, 1'b0, 5'd0, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[4] = '{1'b1, 5'd3, 1'b0, 5'd0, 5'd7, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1};
      vecs[5] = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd7, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[7] = '{1'b0, 5'd0, 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[8] = '{1'b1, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};
      vecs[9] = '{1'b0, 5'd0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0};

      reset = 1'b1;
      idle();
      q_a1 = '0;
      q_a2 = '0;
      tick();
      tick();
      reset = 1'b0;
      #2;
      chk("rst_mdu_ready", {31'd0, mdu_ready}, 32'd1);
      chk("rst_stall", {31'd0, stall_req}, 32'd0);
      chk("rst_proto", {31'd0, proto_err}, 32'd0);
      chk("rst_grf_we", {31'd0, grf_we}, 32'd0);
      chk("rst_busy1", {31'd0, q_busy1}, 32'd0);
      chk("rst_fwd1", q_fwd1, 32'd0);

      // Arbitration and age sequence, then $0 handling
      for (int i = 0; i < 10; i++) begin
         tick();
         idle();
         pipe_we = vecs[i].pwe;
         pipe_a3 = vecs[i].pa3;
         pipe_wd = pwd(vecs[i].pa3);
         pipe_pc = ppc(vecs[i].pa3);
         mdu_valid = vecs[i].mv;
         mdu_a3    = vecs[i].ma3;
         mdu_wd    = mwd(vecs[i].ma3);
         mdu_pc    = mpc(vecs[i].ma3);
         q_a1      = vecs[i].qa;
         if (vecs[i].exp_we) begin
            if (vecs[i].exp_mdu)
               exp_q.push_back('{a3: vecs[i].exp_a3, wd: mwd(vecs[i].exp_a3), pc: mpc(vecs[i].exp_a3)});
            else
               exp_q.push_back('{a3: vecs[i].exp_a3, wd: pwd(vecs[i].exp_a3), pc: ppc(vecs[i].exp_a3)});
         end
         #2;
         chk($sformatf("vec%0d_grf_we", i), {31'd0, grf_we}, {31'd0, vecs[i].exp_we});
         chk($sformatf("vec%0d_stall", i), {31'd0, stall_req}, {31'd0, vecs[i].exp_stall});
         chk($sformatf("vec%0d_rdy", i), {31'd0, mdu_ready}, {31'd0, vecs[i].exp_rdy});
         chk($sformatf("vec%0d_busy1", i), {31'd0, q_busy1}, {31'd0, vecs[i].exp_busy});
      end

      // MDU alone: written the cycle after acceptance
      tick(); idle(); q_a1 = 5'd5;
      set_mdu(5'd5, 32'h1234, 32'h500);
      exp_q.push_back('{a3: 5'd5, wd: 32'h1234, pc: 32'h500});
      #2;
      chk("alone_no_bypass", {31'd0, grf_we}, 32'd0);
      chk("alone_busy_pre", {31'd0, q_busy1}, 32'd0);
      tick(); idle(); #2;
      chk("alone_write", {31'd0, grf_we}, 32'd1);
      chk("alone_busy", {31'd0, q_busy1}, 32'd1);
      chk("alone_fwd", q_fwd1, 32'h1234);
      tick(); idle(); #2;
      chk("alone_idle", {31'd0, grf_we}, 32'd0);
      chk("alone_busy_post", {31'd0, q_busy1}, 32'd0);

      // WAW: pipeline write to 9 kills the buffered 9
      tick(); idle(); q_a1 = 5'd9;
      set_mdu(5'd9, 32'hA, 32'h900);
      #2;
      chk("waw_no_write", {31'd0, grf_we}, 32'd0);
      tick(); idle();
      set_pipe(5'd9, 32'hB, 32'h904, 1'b1);
      #2;
      chk("waw_pipe_wd", grf_wd, 32'hB);
      chk("waw_busy_pre", {31'd0, q_busy1}, 32'd1);
      chk("waw_fwd_pre", q_fwd1, 32'hA);
      tick(); idle(); #2;
      chk("waw_killed", {31'd0, grf_we}, 32'd0);
      chk("waw_busy_post", {31'd0, q_busy1}, 32'd0);
      chk("waw_fwd_post", q_fwd1, 32'd0);
      tick(); idle(); #2;
      chk("waw_still_none", {31'd0, grf_we}, 32'd0);

      // Full FIFO under a busy pipe, then in-order drain in FORCE
      q_a1 = 5'd1; q_a2 = 5'd2;
      tick(); idle();
      set_pipe(5'd3, 32'h33, 32'hC00, 1'b1);
      set_mdu(5'd1, 32'h11, 32'h104);
      #2;
      chk("full_rdy0", {31'd0, mdu_ready}, 32'd1);
      tick(); idle();
      set_pipe(5'd3, 32'h33, 32'hC04, 1'b1);
      set_mdu(5'd2, 32'h22, 32'h108);
      #2;
      chk("full_rdy1", {31'd0, mdu_ready}, 32'd1);
      chk("full_fwd1", q_fwd1, 32'h11);
      tick(); idle();
      set_pipe(5'd3, 32'h33, 32'hC08, 1'b1);
      set_mdu(5'd4, 32'h44, 32'h10C);
      #2;
      chk("full_rdy_low", {31'd0, mdu_ready}, 32'd0);
      chk("full_stall_pre", {31'd0, stall_req}, 32'd0);
      chk("full_fwd2", q_fwd2, 32'h22);
      tick(); idle();
      exp_q.push_back('{a3: 5'd1, wd: 32'h11, pc: 32'h104});
      exp_q.push_back('{a3: 5'd2, wd: 32'h22, pc: 32'h108});
      #2;
      chk("full_force", {31'd0, stall_req}, 32'd1);
      chk("full_drain1", {27'd0, grf_a3}, 32'd1);
      chk("full_rdy_nobypass", {31'd0, mdu_ready}, 32'd0);
      tick(); idle(); #2;
      chk("full_force2", {31'd0, stall_req}, 32'd1);
      chk("full_drain2", {27'd0, grf_a3}, 32'd2);
      chk("full_rdy_back", {31'd0, mdu_ready}, 32'd1);
      tick(); idle(); #2;
      chk("full_normal", {31'd0, stall_req}, 32'd0);
      chk("full_empty", {31'd0, grf_we}, 32'd0);
      chk("full_busy2_post", {31'd0, q_busy2}, 32'd0);

      // Protocol: pipeline write during stall_req sets sticky proto_err
      q_a1 = 5'd6; q_a2 = 5'd0;
      tick(); idle();
      set_pipe(5'd3, 32'h3, 32'hD00, 1'b1);
      set_mdu(5'd6, 32'h66, 32'h118);
      tick(); idle();
      set_pipe(5'd3, 32'h3, 32'hD04, 1'b1);
      set_mdu(5'd8, 32'h88, 32'h11C);
      tick(); idle();
      set_pipe(5'd3, 32'h3, 32'hD08, 1'b1);
      #2;
      chk("proto_stall_pre", {31'd0, stall_req}, 32'd0);
      tick(); idle();
      set_pipe(5'd3, 32'h3, 32'hD0C, 1'b1);
      #2;
      chk("proto_stall", {31'd0, stall_req}, 32'd1);
      chk("proto_not_yet", {31'd0, proto_err}, 32'd0);
      chk("proto_pipe_wins", {27'd0, grf_a3}, 32'd3);
      tick(); idle();
      exp_q.push_back('{a3: 5'd6, wd: 32'h66, pc: 32'h118});
      exp_q.push_back('{a3: 5'd8, wd: 32'h88, pc: 32'h11C});
      #2;
      chk("proto_set", {31'd0, proto_err}, 32'd1);
      tick(); idle(); #2;
      chk("proto_hold1", {31'd0, proto_err}, 32'd1);
      tick(); idle(); #2;
      chk("proto_hold2", {31'd0, proto_err}, 32'd1);
      chk("proto_normal", {31'd0, stall_req}, 32'd0);

      // Reset with two buffered entries: nothing is written
      q_a1 = 5'd12;
      tick(); idle();
      set_pipe(5'd3, 32'h3, 32'hE00, 1'b1);
      set_mdu(5'd12, 32'hCC, 32'h130);
      tick(); idle();
      set_pipe(5'd3, 32'h3, 32'hE04, 1'b1);
      set_mdu(5'd13, 32'hDD, 32'h134);
      tick(); idle();
      reset = 1'b1;
      #2;
      chk("mrst_we_in_reset", {31'd0, grf_we}, 32'd0);
      tick(); idle();
      reset = 1'b0;
      #2;
      chk("mrst_we", {31'd0, grf_we}, 32'd0);
      chk("mrst_rdy", {31'd0, mdu_ready}, 32'd1);
      chk("mrst_stall", {31'd0, stall_req}, 32'd0);
      chk("mrst_proto", {31'd0, proto_err}, 32'd0);
      chk("mrst_busy", {31'd0, q_busy1}, 32'd0);
      chk("mrst_fwd", q_fwd1, 32'd0);
      tick(); idle(); #2;
      chk("mrst_we_after", {31'd0, grf_we}, 32'd0);

      tick();
      chk("exp_queue_empty", 32'(exp_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/grf_wb_arbiter.md
GRF_WB_ARBITER -- requirements
Module: grf_wb_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2: number of buffered late (MDU) write-back entries, power of two, at least 2.
REQ-002 Parameter AGE_MAX, default 4: maximum cycles the FIFO head may wait before a forced drain.
REQ-003 Clock is clk and reset is reset, synchronous, active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  synchronous active-high reset.
REQ-006 pipe_we / pipe_a3 / pipe_wd / pipe_pc  in  1/5/32/32  W-stage write request: enable, destination, data, instruction PC.
REQ-007 mdu_valid / mdu_a3 / mdu_wd / mdu_pc  in  1/5/32/32  late-result write request from the multi-cycle unit.
REQ-008 mdu_ready  out  1  FIFO can accept a late result this cycle.
REQ-009 q_a1, q_a2  in  5  D-stage source register numbers to query.
REQ-010 q_busy1, q_busy2  out  1  queried register has a pending buffered write.
REQ-011 q_fwd1, q_fwd2  out  32  data of the youngest matching buffered entry, 0 if none.
REQ-012 grf_we / grf_a3 / grf_wd / grf_pc  out  1/5/32/32  single GRF write port; grf_pc drives the write trace.
REQ-013 stall_req  out  1  registered request that the pipeline insert a W-stage bubble.
REQ-014 proto_err  out  1  sticky flag for a pipeline write issued while stall_req=1.

Function
REQ-015 The GRF port outputs SHALL be combinational from the current inputs and FIFO head, with the GRF committing the write at the next rising edge.
REQ-016 A pipeline write SHALL be selected when pipe_we=1 and pipe_a3!=0, with zero latency.
REQ-017 Otherwise a non-empty FIFO SHALL drive its head to the port, and the head SHALL dequeue at the edge.
REQ-018 Otherwise grf_we SHALL be 0, and grf_a3, grf_wd and grf_pc SHALL be 0.
REQ-019 mdu_ready SHALL equal (count<FIFO_DEPTH); a same-cycle dequeue SHALL NOT raise mdu_ready (no bypass).
REQ-020 mdu_valid&&mdu_ready SHALL enqueue at the edge; an entry SHALL be written to the GRF no earlier than the cycle after acceptance.
REQ-021 An accepted entry with mdu_a3=0 SHALL be dropped and never enqueued.
REQ-022 All FIFO entries are program-order older than any concurrent pipeline write.
REQ-023 A selected pipeline write to register R SHALL invalidate every FIFO entry with a3=R at the edge, so the later write wins.
REQ-024 Invalidated entries SHALL be skipped at the head with no GRF write and no lost cycle.
REQ-025 Simultaneous enqueue, dequeue and invalidation SHALL all apply in the same cycle.
REQ-026 count SHALL be updated accordingly, with no overflow or underflow and pointer wrap modulo FIFO_DEPTH.
REQ-027 The age counter SHALL increment each cycle a valid head is not written, clear on dequeue or when the FIFO is empty, and saturate at AGE_MAX.
REQ-028 The FSM SHALL have states NORMAL and FORCE.
REQ-029 The FSM SHALL go NORMAL->FORCE at the edge where age reaches AGE_MAX-1 with the head still pending, or where count==FIFO_DEPTH.
REQ-030 The FSM SHALL go FORCE->NORMAL at the edge where the FIFO becomes empty.
REQ-031 stall_req SHALL be 1 exactly in FORCE.
REQ-032 In FORCE a pipeline write SHALL still win arbitration and proto_err SHALL set, remaining set until reset.
REQ-033 q_busyN SHALL be 1 iff q_aN!=0 and a valid FIFO entry has a3==q_aN.
REQ-034 q_fwdN SHALL carry the youngest such entry's data.
REQ-035 Query outputs SHALL reflect state before this cycle's edge.

Reset
REQ-036 While reset=1, grf_we SHALL be 0.
REQ-037 At a reset edge, all entries SHALL be discarded, with count=0, pointers=0, age=0, state=NORMAL, stall_req=0 and proto_err=0.
REQ-038 Reset outputs: mdu_ready=1, q_busy=0, q_fwd=0.
REQ-039 Reset mid-drain SHALL discard pending entries without writing them.

Structure
REQ-040 A shared package SHALL hold the FSM state enum {NORMAL, FORCE} and the entry record {valid, a3[4:0], wd[31:0], pc[31:0]}.
REQ-041 The FIFO storage, pointers and invalidation SHALL be one sub-module, wb_fifo; arbitration, age and FSM stay in the top.

Verification
REQ-042 Scenario, MDU alone: MDU sends a3=5, wd=0x1234 with no pipe_we -> grf_we=1, a3=5, wd=0x1234 the next cycle; FIFO empty afterwards.
REQ-043 Scenario, arbitration: pipe_we every cycle (a3=3) while MDU enqueues a3=7 -> pipe writes each cycle; stall_req rises after 4 waiting cycles; when pipe_we drops, a3=7 is written and stall_req falls the cycle after empty.
REQ-044 Scenario, WAW: MDU enqueues a3=9, wd=0xA, then pipe writes a3=9, wd=0xB before drain -> GRF holds 0xB; entry 9 is never written; q_busy for 9 is 0 after the pipe write.
REQ-045 Scenario, full FIFO: two enqueues (a3=1,2) under a busy pipe -> mdu_ready=0; FORCE entered; pipe_we=0 -> drains 1 then 2 in order; mdu_ready returns to 1.
REQ-046 Scenario, $0 and protocol: MDU a3=0 -> no write; q_a1=0 -> q_busy1=0; pipe_we=1 during stall_req=1 -> proto_err=1, held until reset.
REQ-047 Scenario, mid-drain reset: reset asserted with 2 entries -> no GRF writes; count=0, state=NORMAL the next cycle.
